// File: rtl/apb_cfg_pkg.sv
// Shared types and constants for the APB configuration initiator.
package apb_cfg_pkg;

    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of the ACCESS wait counter; one bit minimum so a disabled timeout still elaborates.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = (cycles == 0) ? 32'd1 : 32'($clog2(cycles + 1));
        return w;
    endfunction

endpackage

// File: rtl/apb_cfg_if.sv
// Request/response handshake plus APB bus bundle for the configuration initiator.
interface apb_cfg_if #(
    parameter int unsigned ADDR_W = 12
) ();
    import apb_cfg_pkg::*;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_W-1:0]         req_addr_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      req_write_i;

    logic                      rsp_valid_o;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;
    logic                      busy_o;

    logic [ADDR_W-1:0]         PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_write_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_write_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_cfg_master.sv
// Single-outstanding APB initiator: valid/ready word requests in, one-cycle response pulse out,
// with an optional bounded wait on PREADY.
import apb_cfg_pkg::*;

module apb_cfg_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic        HCLK,
    input logic        HRESET,
    apb_cfg_if.master  bus
);

    localparam int unsigned DW    = APB_DATA_WIDTH;
    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;

    logic [1:0]       r_state,       w_state;
    logic [CNT_W-1:0] r_cnt,         w_cnt;
    logic             r_req_ready,   w_req_ready;
    logic             r_busy,        w_busy;
    logic [AW-1:0]    r_paddr,       w_paddr;
    logic [DW-1:0]    r_pwdata,      w_pwdata;
    logic             r_pwrite,      w_pwrite;
    logic             r_psel,        w_psel;
    logic             r_penable,     w_penable;
    logic             r_rsp_valid,   w_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata,   w_rsp_rdata;
    logic             r_rsp_err,     w_rsp_err;
    logic             r_rsp_timeout, w_rsp_timeout;

    // Next-state and next-output logic; every register is loaded from its w_ value.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_pwrite      = r_pwrite;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;

        case (r_state)
            ST_IDLE: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                if (bus.req_valid_i && r_req_ready) begin
                    w_paddr  = bus.req_addr_i;
                    w_pwrite = bus.req_write_i;
                    w_pwdata = bus.req_write_i ? bus.req_wdata_i : '0;
                    w_psel   = 1'b1;
                    w_state  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt     = '0;
                w_psel    = 1'b1;
                w_penable = 1'b1;
                w_state   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over a timeout landing on the same cycle.
                if (bus.PREADY) begin
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = bus.PSLVERR;
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = (!r_pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_IDLE;
                end else if (TO_EN && (r_cnt == CNT_LAST)) begin
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_rdata   = '0;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_state       = ST_IDLE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                w_state   = ST_IDLE;
            end
        endcase

        w_req_ready = (w_state == ST_IDLE);
        w_busy      = (w_state != ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_req_ready   <= w_req_ready;
            r_busy        <= w_busy;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_pwrite      <= w_pwrite;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    assign bus.req_ready_o   = r_req_ready;
    assign bus.busy_o        = r_busy;
    assign bus.PADDR         = r_paddr;
    assign bus.PWDATA        = r_pwdata;
    assign bus.PWRITE        = r_pwrite;
    assign bus.PSEL          = r_psel;
    assign bus.PENABLE       = r_penable;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with a response scoreboard.
module tb_apb_cfg_master;

    logic HCLK = 1'b0;
    logic HRESET;

    apb_cfg_if #(.ADDR_W(12)) bus ();

    apb_cfg_master #(
        .APB_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic        auto_rd;
    logic [31:0] prdata_drv;

    // Simple responder: address-derived read data in auto mode, otherwise a directed value.
    always_comb bus.PRDATA = auto_rd ? (32'hC0DE_0000 | 32'(bus.PADDR)) : prdata_drv;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] rdata, input logic err, input logic to);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.to    = to;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        rsp_t e;
        chk1({tag, "_sb_entry"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk32({tag, "_rdata"}, bus.rsp_rdata_o, e.rdata);
            chk1({tag, "_err"}, bus.rsp_err_o, e.err);
            chk1({tag, "_timeout"}, bus.rsp_timeout_o, e.to);
        end
    endtask

    // Advance until a response pulse (bounded); n returns the number of cycles waited.
    task automatic do_rsp(input string tag, input int max_cyc, output int n);
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk1({tag, "_rsp_seen"}, bus.rsp_valid_o, 1'b1);
        if (bus.rsp_valid_o === 1'b1) pop_check(tag);
    endtask

    task automatic drive_req(input logic [11:0] addr, input logic [31:0] wdata, input logic wr);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        bus.req_write_i = wr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc_cyc[3];
        int n_acc;
        int n_rsp;
        int lows;
        logic acc;

        HRESET          = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_write_i = 1'b0;
        bus.PREADY      = 1'b1;
        bus.PSLVERR     = 1'b0;
        auto_rd         = 1'b0;
        prdata_drv      = '0;

        // Reset state
        repeat (3) tick();
        chk1("rst_psel", bus.PSEL, 1'b0);
        chk1("rst_penable", bus.PENABLE, 1'b0);
        chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        chk1("rst_ready", bus.req_ready_o, 1'b0);
        chk1("rst_busy", bus.busy_o, 1'b0);
        HRESET = 1'b0;
        tick();
        chk1("idle_ready", bus.req_ready_o, 1'b1);

        // Zero-wait write
        drive_req(12'h004, 32'h0000_0001, 1'b1);
        push(32'h0, 1'b0, 1'b0);
        tick();
        bus.req_valid_i = 1'b0;
        chk1("wr_setup_psel", bus.PSEL, 1'b1);
        chk1("wr_setup_penable", bus.PENABLE, 1'b0);
        chk32("wr_paddr", 32'(bus.PADDR), 32'h004);
        chk1("wr_pwrite", bus.PWRITE, 1'b1);
        chk32("wr_pwdata", bus.PWDATA, 32'h1);
        chk1("wr_busy", bus.busy_o, 1'b1);
        chk1("wr_ready_low", bus.req_ready_o, 1'b0);
        tick();
        chk1("wr_access_psel", bus.PSEL, 1'b1);
        chk1("wr_access_penable", bus.PENABLE, 1'b1);
        tick();
        do_rsp("wr", 0, n);
        chk1("wr_rsp_psel", bus.PSEL, 1'b0);
        chk1("wr_rsp_ready", bus.req_ready_o, 1'b1);
        tick();
        chk1("wr_rsp_pulse_end", bus.rsp_valid_o, 1'b0);

        // Read with three wait states; PREADY arrives as the counter hits its limit
        drive_req(12'h010, 32'hFFFF_FFFF, 1'b0);
        bus.PREADY = 1'b0;
        prdata_drv = 32'h0000_1234;
        push(32'h0000_0802, 1'b0, 1'b0);
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 12'hFFF;
        chk32("rd_pwdata_zero", bus.PWDATA, 32'h0);
        chk1("rd_pwrite", bus.PWRITE, 1'b0);
        repeat (4) tick();
        chk1("rd_wait_penable", bus.PENABLE, 1'b1);
        chk1("rd_wait_no_rsp", bus.rsp_valid_o, 1'b0);
        chk32("rd_paddr_stable", 32'(bus.PADDR), 32'h010);
        bus.PREADY = 1'b1;
        prdata_drv = 32'h0000_0802;
        do_rsp("rd_wait", 5, n);
        chk32("rd_wait_cycles", 32'(n), 32'd1);
        tick();
        chk1("rd_pulse_end", bus.rsp_valid_o, 1'b0);
        chk32("rd_rdata_hold", bus.rsp_rdata_o, 32'h0000_0802);

        // Read with PSLVERR
        drive_req(12'h020, 32'h0, 1'b0);
        bus.PSLVERR = 1'b1;
        prdata_drv  = 32'hDEAD_BEEF;
        push(32'h0, 1'b1, 1'b0);
        tick();
        bus.req_valid_i = 1'b0;
        do_rsp("slverr", 5, n);
        chk32("slverr_cycles", 32'(n), 32'd2);
        bus.PSLVERR = 1'b0;
        tick();

        // Timeout after four ACCESS wait cycles
        drive_req(12'h030, 32'h0, 1'b0);
        bus.PREADY = 1'b0;
        prdata_drv = 32'hBAD0_BAD0;
        push(32'h0, 1'b1, 1'b1);
        tick();
        bus.req_valid_i = 1'b0;
        repeat (4) tick();
        chk1("to_wait_psel", bus.PSEL, 1'b1);
        chk1("to_wait_no_rsp", bus.rsp_valid_o, 1'b0);
        do_rsp("timeout", 5, n);
        chk32("to_cycles", 32'(n), 32'd1);
        chk1("to_psel_drop", bus.PSEL, 1'b0);
        chk1("to_penable_drop", bus.PENABLE, 1'b0);
        chk1("to_ready", bus.req_ready_o, 1'b1);

        // Back-to-back requests with req_valid_i held high
        bus.PREADY = 1'b1;
        auto_rd    = 1'b1;
        drive_req(12'h100, 32'h0, 1'b0);
        n_acc = 0;
        n_rsp = 0;
        lows  = 0;
        for (int cyc = 0; cyc < 30 && n_rsp < 3; cyc++) begin
            acc = bus.req_valid_i && bus.req_ready_o;
            if (acc) begin
                case (n_acc)
                    0:       push(32'hC0DE_0100, 1'b0, 1'b0);
                    1:       push(32'h0, 1'b0, 1'b0);
                    default: push(32'hC0DE_0108, 1'b0, 1'b0);
                endcase
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            if (acc) begin
                case (n_acc)
                    1:       drive_req(12'h104, 32'h0000_0055, 1'b1);
                    2:       drive_req(12'h108, 32'h0, 1'b0);
                    default: bus.req_valid_i = 1'b0;
                endcase
            end
            if (bus.rsp_valid_o === 1'b1) begin
                pop_check("b2b");
                n_rsp++;
            end
            if (n_acc > 0 && n_rsp < 3 && bus.PSEL === 1'b0) lows++;
        end
        bus.req_valid_i = 1'b0;
        chk32("b2b_rsp_count", 32'(n_rsp), 32'd3);
        chk32("b2b_acc_count", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            chk32("b2b_acc_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk32("b2b_acc_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        chk32("b2b_psel_low", 32'(lows), 32'd2);
        auto_rd = 1'b0;
        tick();

        // Reset in the middle of ACCESS with the slave stalled
        drive_req(12'h040, 32'h0, 1'b0);
        bus.PREADY = 1'b0;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        tick();
        chk1("rstmid_in_access", bus.PENABLE, 1'b1);
        HRESET = 1'b1;
        tick();
        chk1("rstmid_psel", bus.PSEL, 1'b0);
        chk1("rstmid_penable", bus.PENABLE, 1'b0);
        chk1("rstmid_rsp", bus.rsp_valid_o, 1'b0);
        chk1("rstmid_busy", bus.busy_o, 1'b0);
        HRESET     = 1'b0;
        bus.PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rstmid_no_rsp", bus.rsp_valid_o, 1'b0);
        end
        drive_req(12'h008, 32'h0000_CAFE, 1'b1);
        push(32'h0, 1'b0, 1'b0);
        tick();
        bus.req_valid_i = 1'b0;
        chk32("post_rst_pwdata", bus.PWDATA, 32'h0000_CAFE);
        do_rsp("post_rst", 5, n);
        chk32("post_rst_cycles", 32'(n), 32'd2);
        chk32("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
- Single-outstanding APB initiator driving the pad-mux, clock-gate and boot-address configuration peripheral, and any other APB responder on the same bus.
- Accepts word requests on a valid/ready interface and runs the APB SETUP/ACCESS sequence.
- Waits on PREADY, bounded by a timeout.
- Returns read data, PSLVERR and timeout status as a one-cycle response pulse.
- Sits between a boot/config sequencer (or debug port) and the peripheral APB bus.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
- TIMEOUT_CYCLES, 255, ACCESS wait cycles without PREADY before abort; 0 disables the timeout.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_addr_i  in  APB_ADDR_WIDTH  byte address
- req_wdata_i  in  32  write data
- req_write_i  in  1  1 = write, 0 = read
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure
- rsp_rdata_o  out  32  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  PSLVERR seen, or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- busy_o  out  1  state != IDLE
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset: synchronous on HRESET. All outputs go to 0, state goes to IDLE, timeout counter clears. Reset during SETUP or ACCESS drops PSEL/PENABLE at that edge and produces no response.
- Three-state FSM: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register addr, wdata and write. PWDATA is forced to 0 for reads. Go to SETUP.
  - PSEL = 0 and PENABLE = 0. PADDR/PWRITE/PWDATA hold their last values.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - Clear the timeout counter, then go to ACCESS.
  - PREADY and PSLVERR are ignored.
- ACCESS:
  - PSEL = 1, PENABLE = 1. PADDR/PWDATA/PWRITE stay stable.
  - PREADY = 1: sample PRDATA (reads only) and PSLVERR. Next cycle: rsp_valid_o = 1, rsp_err_o = PSLVERR, rsp_timeout_o = 0. Go to IDLE.
  - PREADY = 0: increment the counter.
  - Timeout: TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES with PREADY still 0. Deassert PSEL/PENABLE next cycle. Pulse rsp_valid_o with rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0. Go to IDLE.
  - PREADY = 1 on the same cycle the counter hits the limit: the transfer completes normally; PREADY has priority.
- Counter: width is $clog2(TIMEOUT_CYCLES+1), saturating. Unused when TIMEOUT_CYCLES = 0, so a stalled slave hangs forever.
- Latency, zero-wait slave:
  - Accept at cycle n, SETUP at n+1, ACCESS at n+2, rsp_valid_o at n+3.
  - The next request can be accepted at n+3.
  - Throughput: 1 transfer per 3 cycles.
- rsp_rdata_o, rsp_err_o and rsp_timeout_o hold their values until the next response.
- req_* inputs are sampled only on accept; changes afterwards are ignored.

Decomposition:
- Shared package apb_cfg_pkg contains:
  - apb_state_e enum {IDLE, SETUP, ACCESS};
  - APB_DATA_WIDTH = 32;
  - a localparam function for the counter width.
- No sub-module. FSM, counter and response register live in one module.
- The counter could be split out as apb_timeout_cnt if other initiators reuse it.

Test Plan:
- Write 0x0000_0001 to 0x004, PREADY tied 1:
  - PSEL rises at n+1 and PENABLE at n+2, with PADDR = 0x004, PWRITE = 1, PWDATA = 0x1;
  - rsp_valid_o at n+3 with err = 0, rdata = 0.
- Read 0x010 with 3 PREADY-low cycles, then PREADY = 1 with PRDATA = 0x0000_0802:
  - ACCESS lasts 4 cycles;
  - rsp_rdata_o = 0x0000_0802, err = 0, PWDATA = 0.
- Read with PSLVERR = 1 and PRDATA = 0xDEAD_BEEF on the PREADY cycle: rsp_err_o = 1, rsp_timeout_o = 0, rsp_rdata_o = 0.
- TIMEOUT_CYCLES = 4, PREADY held 0:
  - abort after 4 ACCESS wait cycles; PSEL drops;
  - rsp_valid_o with err = 1 and timeout = 1;
  - req_ready_o returns to 1.
- Back-to-back: req_valid_i held high for 3 requests → accepts at cycles 0, 3, 6; 3 responses in order; PSEL low for one cycle between transfers.
- HRESET asserted during ACCESS with PREADY = 0:
  - PSEL/PENABLE = 0 at the next edge and no rsp_valid_o;
  - a new request after reset completes normally.
